// File: rtl/eth_src_packer.sv
// Source selector and lane packer feeding the SIG-ETHERNET FIFO. One of NUM_CH
// source FIFOs is read at a time; narrow channels are packed MSB-first, wide channels pass through.
// Optional feature: define PARTIAL_FLUSH_EN to emit a zero-padded partial word after IDLE_TIMEOUT idle cycles.
module eth_src_packer #(
    parameter int                NUM_CH       = 4,
    parameter int                LANE_W       = 8,
    parameter int                OUT_LANES    = 4,
    parameter logic [NUM_CH-1:0] NARROW_MASK  = 4'b0001,
    parameter int                RD_LAT       = 1,
    parameter int                FLUSH_CYC    = 4,
    parameter int                DEFAULT_CH   = 0,
    parameter int                IDLE_TIMEOUT = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CH-1:0]                    sel_pulse,
    input  logic                                 off_pulse,
    input  logic [NUM_CH*LANE_W*OUT_LANES-1:0]   src_data,
    input  logic [NUM_CH-1:0]                    src_almost_empty,
    output logic [NUM_CH-1:0]                    src_rd_en,
    output logic                                 out_wr_en,
    output logic [LANE_W*OUT_LANES-1:0]          out_data,
    input  logic                                 out_almost_full,
    input  logic                                 out_full,
    output logic                                 out_fifo_rst,
    output logic [NUM_CH-1:0]                    active_ch,
    output logic                                 overflow
);

    localparam int OUT_W = LANE_W * OUT_LANES;
    localparam int LCW   = (OUT_LANES > 1) ? $clog2(OUT_LANES) : 1;
    localparam int FCW   = $clog2(FLUSH_CYC + 1);
    localparam logic [NUM_CH-1:0] DEF_OH = NUM_CH'(1) << DEFAULT_CH;

    if (RD_LAT < 1 || RD_LAT > 3 || FLUSH_CYC < 1 || IDLE_TIMEOUT < 1) begin : g_param_check
        $error("eth_src_packer: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_RUN = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   active_ch_q, active_ch_d;
    logic                off_req_q, off_req_d;
    logic [FCW-1:0]      fcnt_q, fcnt_d;
    logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d;
    logic [LCW-1:0]      lane_cnt_q, lane_cnt_d;
    logic [OUT_W-1:0]    buf_q, buf_d;
    logic                out_wr_en_q, out_wr_en_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                overflow_q, overflow_d;
`ifdef PARTIAL_FLUSH_EN
    localparam int ICW = $clog2(IDLE_TIMEOUT + 1);
    logic [ICW-1:0]      idle_cnt_q, idle_cnt_d;
`endif

    logic [NUM_CH-1:0]   sel_oh;
    logic                sel_valid;
    logic                flush_start;
    logic                flush_last;
    logic                cap;
    logic                is_narrow;
    logic [OUT_W-1:0]    src_word;
    logic                word_done;
    logic [OUT_W-1:0]    word;

    // Lowest-index select wins; re-selecting the live channel is a no-op unless an off is pending
    always_comb begin
        sel_oh = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (sel_pulse[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
        sel_valid   = (|sel_pulse) && ((sel_oh != active_ch_q) || off_req_q);
        flush_start = off_pulse || sel_valid;
        flush_last  = (state_q == S_FLUSH) && (fcnt_q == FCW'(FLUSH_CYC - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_start) begin
            state_d = S_FLUSH;
        end else if (flush_last) begin
            state_d = off_req_q ? S_IDLE : S_RUN;
        end
    end

    always_comb begin
        out_fifo_rst = (state_q == S_FLUSH);
        src_rd_en    = {NUM_CH{(state_q == S_RUN) && !out_almost_full}} & active_ch_q & ~src_almost_empty;
    end

    always_comb begin
        active_ch_d = active_ch_q;
        off_req_d   = off_req_q;
        fcnt_d      = fcnt_q;
        if (off_pulse) begin
            off_req_d = 1'b1;
            fcnt_d    = '0;
        end else if (sel_valid) begin
            active_ch_d = sel_oh;
            off_req_d   = 1'b0;
            fcnt_d      = '0;
        end else if (flush_last) begin
            fcnt_d = '0;
            if (off_req_q) begin
                active_ch_d = '0;
                off_req_d   = 1'b0;
            end
        end else if (state_q == S_FLUSH) begin
            fcnt_d = fcnt_q + FCW'(1);
        end
    end

    // Capture, pack and write; a flush start overrides everything in flight
    always_comb begin
        cap       = rd_pipe_q[RD_LAT-1];
        rd_pipe_d = RD_LAT'({rd_pipe_q, |src_rd_en});
        is_narrow = |(active_ch_q & NARROW_MASK);
        src_word  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (active_ch_q[i]) src_word = src_word | src_data[i*OUT_W +: OUT_W];
        end
        buf_d       = buf_q;
        lane_cnt_d  = lane_cnt_q;
        out_wr_en_d = 1'b0;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;
        word_done   = 1'b0;
        word        = '0;
        if (cap) begin
            if (is_narrow) begin
                buf_d = {buf_q[OUT_W-LANE_W-1:0], src_word[LANE_W-1:0]};
                if (lane_cnt_q == LCW'(OUT_LANES - 1)) begin
                    lane_cnt_d = '0;
                    word_done  = 1'b1;
                    word       = buf_d;
                end else begin
                    lane_cnt_d = lane_cnt_q + LCW'(1);
                end
            end else begin
                lane_cnt_d = '0;
                word_done  = 1'b1;
                word       = src_word;
            end
        end
`ifdef PARTIAL_FLUSH_EN
        idle_cnt_d = idle_cnt_q;
        if (cap || (lane_cnt_q == '0) || !is_narrow || (state_q != S_RUN)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == ICW'(IDLE_TIMEOUT - 1)) begin
            idle_cnt_d = '0;
            lane_cnt_d = '0;
            word_done  = 1'b1;
            word       = buf_q << (LANE_W * (OUT_LANES - int'(lane_cnt_q)));
        end else begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
        end
`endif
        if (word_done) begin
            out_wr_en_d = 1'b1;
            out_data_d  = word;
            if (out_full) overflow_d = 1'b1;
        end
        if (flush_start) begin
            buf_d       = '0;
            lane_cnt_d  = '0;
            rd_pipe_d   = '0;
            out_wr_en_d = 1'b0;
            out_data_d  = out_data_q;
`ifdef PARTIAL_FLUSH_EN
            idle_cnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_ch_q <= DEF_OH;
            off_req_q   <= 1'b0;
            fcnt_q      <= '0;
            rd_pipe_q   <= '0;
            lane_cnt_q  <= '0;
            buf_q       <= '0;
            out_wr_en_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
`ifdef PARTIAL_FLUSH_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            active_ch_q <= active_ch_d;
            off_req_q   <= off_req_d;
            fcnt_q      <= fcnt_d;
            rd_pipe_q   <= rd_pipe_d;
            lane_cnt_q  <= lane_cnt_d;
            buf_q       <= buf_d;
            out_wr_en_q <= out_wr_en_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
`ifdef PARTIAL_FLUSH_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign active_ch = active_ch_q;
    assign out_wr_en = out_wr_en_q;
    assign out_data  = out_data_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_eth_src_packer.sv
// Bench for eth_src_packer: directed scenarios plus random traffic, all checked
// against a transaction-level model built from timestamps and lane queues.
module tb_eth_src_packer;

    localparam int RD_LAT    = 1;
    localparam int FLUSH_CYC = 4;
    localparam int IDLE_TO   = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   sel_pulse = '0;
    logic         off_pulse = 1'b0;
    logic [127:0] src_data = '0;
    logic [3:0]   src_almost_empty = '1;
    logic [3:0]   src_rd_en;
    logic         out_wr_en;
    logic [31:0]  out_data;
    logic         out_almost_full = 1'b0;
    logic         out_full = 1'b0;
    logic         out_fifo_rst;
    logic [3:0]   active_ch;
    logic         overflow;

    eth_src_packer dut (
        .clk(clk), .rst_n(rst_n), .sel_pulse(sel_pulse), .off_pulse(off_pulse),
        .src_data(src_data), .src_almost_empty(src_almost_empty), .src_rd_en(src_rd_en),
        .out_wr_en(out_wr_en), .out_data(out_data), .out_almost_full(out_almost_full),
        .out_full(out_full), .out_fifo_rst(out_fifo_rst), .active_ch(active_ch),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: channel 0 is narrow, the rest wide
    localparam logic [3:0] NARROW = 4'b0001;
    int          cyc = 0;
    int          m_ch = 0;
    bit          m_off = 0;
    int          m_flush_end = -1;
    bit          m_wr = 0;
    logic [31:0] m_data = '0;
    bit          m_ovf = 0;
    int          m_idle = 0;
    int          pend[$];
    logic [7:0]  lanes[$];
    logic [31:0] feed[$];

    int          n_wr = 0, n_rst = 0, last_wr_cyc = 0, last_rd_cyc = 0;
    logic [31:0] last_wr = '0;
    logic [3:0]  obs_act;
    logic        obs_ovf;

    task automatic step(input logic [3:0] sel, input logic off, input logic [3:0] ae,
                        input logic af, input logic full);
        logic [127:0] d;
        logic [3:0]   e_act, e_rd;
        logic [31:0]  w;
        bit           in_fl, cap_now, done, fs;
        int           lowest;
        @(negedge clk);
        if (m_off && cyc > m_flush_end) begin
            m_ch  = -1;
            m_off = 0;
        end
        in_fl   = (cyc <= m_flush_end);
        cap_now = (pend.size() > 0) && (pend[0] == cyc);
        d = {$urandom, $urandom, $urandom, $urandom};
        if (cap_now && m_ch >= 0 && feed.size() > 0) d[m_ch*32 +: 32] = feed.pop_front();
        src_data = d; sel_pulse = sel; off_pulse = off;
        src_almost_empty = ae; out_almost_full = af; out_full = full;
        #1;
        e_act = (m_ch >= 0) ? 4'(1 << m_ch) : 4'b0000;
        e_rd  = (!in_fl && m_ch >= 0 && !ae[m_ch] && !af) ? e_act : 4'b0000;
        chk("active_ch", active_ch, e_act);
        chk("src_rd_en", src_rd_en, e_rd);
        chk("out_fifo_rst", out_fifo_rst, in_fl);
        chk("out_wr_en", out_wr_en, m_wr);
        chk("out_data", out_data, m_data);
        chk("overflow", overflow, m_ovf);
        obs_act = active_ch;
        obs_ovf = overflow;
        if (out_wr_en) begin n_wr++; last_wr = out_data; last_wr_cyc = cyc; end
        if (src_rd_en != 0) last_rd_cyc = cyc;
        if (out_fifo_rst) n_rst++;

        done = 0;
        w    = '0;
        if (cap_now) begin
            void'(pend.pop_front());
            if (NARROW[m_ch]) begin
                lanes.push_back(d[m_ch*32 +: 8]);
                if (lanes.size() == 4) begin
                    done = 1;
                    w = {lanes[0], lanes[1], lanes[2], lanes[3]};
                    lanes.delete();
                end
            end else begin
                done = 1;
                w = d[m_ch*32 +: 32];
            end
        end
`ifdef PARTIAL_FLUSH_EN
        if (!cap_now && !in_fl && m_ch == 0 && lanes.size() > 0) begin
            m_idle++;
            if (m_idle == IDLE_TO) begin
                done = 1;
                for (int k = 0; k < lanes.size(); k++) w[31-8*k -: 8] = lanes[k];
                lanes.delete();
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
`endif
        if (done && full) m_ovf = 1;
        if (e_rd != 0) pend.push_back(cyc + RD_LAT);
        lowest = -1;
        for (int i = 3; i >= 0; i--) if (sel[i]) lowest = i;
        fs = off || (lowest >= 0 && (lowest != m_ch || m_off));
        m_wr = done && !fs;
        if (m_wr) m_data = w;
        if (fs) begin
            lanes.delete();
            pend.delete();
            m_idle = 0;
            m_flush_end = cyc + FLUSH_CYC;
            if (off) m_off = 1;
            else begin m_ch = lowest; m_off = 0; end
        end
        cyc++;
    endtask

    task automatic idle_steps(input int n, input logic [3:0] ae);
        for (int i = 0; i < n; i++) step(4'b0000, 1'b0, ae, 1'b0, 1'b0);
    endtask

    int          w0, r0;
    logic [3:0]  rae;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_active_ch", active_ch, 4'b0001);
        chk("rst_wr_en", out_wr_en, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_fifo_rst", out_fifo_rst, 1'b0);
        chk("rst_overflow", overflow, 1'b0);

        // Narrow packing on the default channel
        w0 = n_wr;
        feed.push_back(32'h11); feed.push_back(32'h22); feed.push_back(32'h33); feed.push_back(32'h44);
        idle_steps(4, 4'b1110);
        idle_steps(5, 4'b1111);
        chk("t1_nwr", n_wr - w0, 1);
        chk("t1_word", last_wr, 32'h11223344);
        chk("t1_latency", last_wr_cyc - last_rd_cyc, RD_LAT + 1);

        // Switch to wide channel 1
        w0 = n_wr; r0 = n_rst;
        feed.push_back(32'hDEADBEEF);
        step(4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC, 4'b0000);
        idle_steps(1, 4'b1101);
        idle_steps(4, 4'b1111);
        chk("t2_rst_cycles", n_rst - r0, FLUSH_CYC);
        chk("t2_nwr", n_wr - w0, 1);
        chk("t2_word", last_wr, 32'hDEADBEEF);

        // Partial narrow word dropped by a channel change
        step(4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC, 4'b1111);
        w0 = n_wr;
        idle_steps(2, 4'b1110);
        idle_steps(3, 4'b1111);
        step(4'b0100, 1'b0, 4'b1111, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC + 3, 4'b1111);
        chk("t3_no_write", n_wr - w0, 0);
        step(4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC, 4'b1111);
        feed.push_back(32'hA1); feed.push_back(32'hA2); feed.push_back(32'hA3); feed.push_back(32'hA4);
        idle_steps(4, 4'b1110);
        idle_steps(3, 4'b1111);
        chk("t3_fresh_word", last_wr, 32'hA1A2A3A4);

        // Priority: lowest select wins, off beats everything
        step(4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0);
        idle_steps(1, 4'b1111);
        chk("t4_sel_lowest", obs_act, 4'b0010);
        idle_steps(FLUSH_CYC, 4'b1111);
        r0 = n_rst;
        step(4'b0110, 1'b1, 4'b0000, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC, 4'b0000);
        chk("t4_flush_len", n_rst - r0, FLUSH_CYC);
        idle_steps(3, 4'b0000);
        chk("t4_idle_act", obs_act, 4'b0000);

        // Back-pressure with in-flight completion, and sticky overflow
        step(4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);
        idle_steps(FLUSH_CYC, 4'b1111);
        w0 = n_wr;
        feed.push_back(32'hB1); feed.push_back(32'hB2); feed.push_back(32'hB3); feed.push_back(32'hB4);
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 4'b1110, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 4'b1110, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(4'b0000, 1'b0, 4'b1110, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1);
        chk("t5_word", last_wr, 32'hB1B2B3B4);
        chk("t5_nwr", n_wr - w0, 1);
        idle_steps(10, 4'b1111);
        chk("t5_ovf_sticky", obs_ovf, 1'b1);

        // Partial word behaviour after the source runs dry
        w0 = n_wr;
        feed.push_back(32'hAA); feed.push_back(32'hBB);
        idle_steps(2, 4'b1110);
        idle_steps(IDLE_TO + 8, 4'b1111);
`ifdef PARTIAL_FLUSH_EN
        chk("t6_partial_nwr", n_wr - w0, 1);
        chk("t6_partial_word", last_wr, 32'hAABB0000);
`else
        chk("t6_partial_held", n_wr - w0, 0);
`endif

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rae = '0;
            for (int b = 0; b < 4; b++) rae[b] = ($urandom_range(0, 9) < 3);
            step(($urandom_range(0, 49) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                 ($urandom_range(0, 149) == 0), rae,
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
